// File: rtl/ram_fifo_arb_pkg.sv
// ram_fifo_arb_pkg
// Shared definitions for the Block-RAM FIFO write arbiter:
//   - arb_state_t : arbiter state (IDLE waits for a request, LOCK holds a packet grant)
//   - src_w()     : width of a producer index, never less than one bit
package ram_fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  // A single producer still needs a one-bit index.
  function automatic int src_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// rr_arb_pick
// Combinational rotating-priority picker. It scans the request vector
// cyclically, starting at the entry just after ptr, and returns the first
// request it finds. The entry at ptr has the lowest priority.
// Ports:
//   req    in  N_REQ  request vector
//   ptr    in  SRC_W  index of the most recently served producer
//   winner out SRC_W  index of the selected requester (0 when none)
//   found  out 1      at least one request is present
module rr_arb_pick #(
  parameter int N_REQ = 4,
  parameter int SRC_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SRC_W-1:0] ptr,
  output logic [SRC_W-1:0] winner,
  output logic             found
);

  logic [SRC_W-1:0] idx;

  // Offset 1 is checked first, so ptr itself is visited last. The loop
  // stops updating once the first hit has been recorded.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = SRC_W'((int'(ptr) + i) % N_REQ);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/ram_fifo_wr_arb.sv
// ram_fifo_wr_arb
// Round-robin, packet-atomic arbiter in front of a Block-RAM FIFO write port.
// A producer keeps its grant from the first beat through its last beat, so
// packets from different producers never interleave in the FIFO. One IDLE
// cycle separates consecutive packets.
// Optional build macro: ARB_SRCID_EN. When it is defined, each FIFO word
// carries the granted producer index above the payload.
// Ports:
//   clk           in  1                clock, rising edge
//   rst           in  1                asynchronous active-high reset
//   i_valid       in  N_REQ            per-producer beat valid
//   i_data        in  N_REQ*DATA_W     per-producer payload (producer k at [k*DATA_W +: DATA_W])
//   i_last        in  N_REQ            per-producer last-beat flag
//   o_ready       out N_REQ            per-producer beat accept (one-hot or zero)
//   i_fifo_full   in  1                FIFO full flag
//   o_fifo_wren   out 1                FIFO write enable
//   o_fifo_wrdata out DATA_W(+SRC_W)   FIFO write data
//   o_gnt_id      out SRC_W            granted producer index
//   o_busy        out 1                a packet grant is held
module ram_fifo_wr_arb
  import ram_fifo_arb_pkg::*;
#(
  parameter  int N_REQ  = 4,
  parameter  int DATA_W = 8,
  localparam int SRC_W  = src_w(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          i_valid,
  input  logic [N_REQ*DATA_W-1:0]   i_data,
  input  logic [N_REQ-1:0]          i_last,
  output logic [N_REQ-1:0]          o_ready,
  input  logic                      i_fifo_full,
  output logic                      o_fifo_wren,
`ifdef ARB_SRCID_EN
  output logic [DATA_W+SRC_W-1:0]   o_fifo_wrdata,
`else
  output logic [DATA_W-1:0]         o_fifo_wrdata,
`endif
  output logic [SRC_W-1:0]          o_gnt_id,
  output logic                      o_busy
);

  arb_state_t       state, state_nxt;
  logic [SRC_W-1:0] rr_ptr;
  logic [SRC_W-1:0] gnt_id;
  logic [SRC_W-1:0] pick_id;
  logic             pick_found;
  logic [N_REQ-1:0] gnt_sel;
  logic [DATA_W-1:0] payload;
  logic             gnt_valid;
  logic             gnt_last;
  logic             accept;

  rr_arb_pick #(
    .N_REQ (N_REQ),
    .SRC_W (SRC_W)
  ) u_pick (
    .req    (i_valid),
    .ptr    (rr_ptr),
    .winner (pick_id),
    .found  (pick_found)
  );

  // Decode the held grant into a one-hot select and mux the granted
  // producer's payload, valid and last with constant indices.
  always_comb begin
    gnt_sel = '0;
    payload = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt_id == SRC_W'(k)) begin
        gnt_sel[k] = 1'b1;
        payload    = i_data[k*DATA_W +: DATA_W];
      end
    end
  end

  assign gnt_valid = |(i_valid & gnt_sel);
  assign gnt_last  = |(i_last & gnt_sel);

  // Ready follows the full flag combinationally so a write never lands on
  // a full FIFO; a beat is taken only when the granted producer is valid.
  always_comb begin
    state_nxt = state;
    o_ready   = '0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) state_nxt = LOCK;
      end
      LOCK: begin
        if (!i_fifo_full) o_ready = gnt_sel;
        accept = gnt_valid && !i_fifo_full;
        if (accept && gnt_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The grant is captured on the IDLE->LOCK transition; the round-robin
  // pointer advances only when a packet completes, so the finishing
  // producer becomes the lowest priority for the next arbitration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= SRC_W'(N_REQ - 1);
      gnt_id <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && pick_found) gnt_id <= pick_id;
      if (accept && gnt_last) rr_ptr <= gnt_id;
    end
  end

  assign o_fifo_wren = accept;
  assign o_gnt_id    = gnt_id;
  assign o_busy      = (state == LOCK);

  // Write data is forced to zero outside accepted beats so the bus is quiet
  // when nothing is written.
`ifdef ARB_SRCID_EN
  assign o_fifo_wrdata = accept ? {gnt_id, payload} : '0;
`else
  assign o_fifo_wrdata = accept ? payload : '0;
`endif

endmodule

// File: tb/tb_ram_fifo_wr_arb.sv
// tb_ram_fifo_wr_arb
// Directed bench for ram_fifo_wr_arb with N_REQ = 4, DATA_W = 8. Inputs are
// driven 1 time unit after each rising edge and outputs sampled 1 unit later.
// Builds with or without ARB_SRCID_EN; the expected write word adapts.
module tb_ram_fifo_wr_arb;

  localparam int N_REQ  = 4;
  localparam int DATA_W = 8;
`ifdef ARB_SRCID_EN
  localparam int FW = DATA_W + 2;
`else
  localparam int FW = DATA_W;
`endif

  logic                    clk;
  logic                    rst;
  logic [N_REQ-1:0]        i_valid;
  logic [N_REQ*DATA_W-1:0] i_data;
  logic [N_REQ-1:0]        i_last;
  logic [N_REQ-1:0]        o_ready;
  logic                    i_fifo_full;
  logic                    o_fifo_wren;
  logic [FW-1:0]           o_fifo_wrdata;
  logic [1:0]              o_gnt_id;
  logic                    o_busy;

  int checkCount = 0;
  int passCount  = 0;

  ram_fifo_wr_arb #(
    .N_REQ  (N_REQ),
    .DATA_W (DATA_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_valid       (i_valid),
    .i_data        (i_data),
    .i_last        (i_last),
    .o_ready       (o_ready),
    .i_fifo_full   (i_fifo_full),
    .o_fifo_wren   (o_fifo_wren),
    .o_fifo_wrdata (o_fifo_wrdata),
    .o_gnt_id      (o_gnt_id),
    .o_busy        (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected FIFO word for a beat from producer id carrying payload p.
  function automatic logic [31:0] expWr(input int id, input logic [7:0] p);
`ifdef ARB_SRCID_EN
    return {22'd0, id[1:0], p};
`else
    return {24'd0, p};
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] last,
                               input logic full);
    i_valid     = valid;
    i_last      = last;
    i_fifo_full = full;
  endtask

  task automatic setData(input int k, input logic [7:0] val);
    i_data[k*DATA_W +: DATA_W] = val;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) begin
      passCount++;
    end else begin
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Samples all outputs 1 unit after the inputs settle.
  task automatic checkAll(input string tag, input logic [3:0] rdy, input logic wren,
                          input logic [31:0] wrdata, input logic busy);
    #1;
    checkOutput({tag, "_ready"},  32'(o_ready),       32'(rdy));
    checkOutput({tag, "_wren"},   32'(o_fifo_wren),   32'(wren));
    checkOutput({tag, "_wrdata"}, 32'(o_fifo_wrdata), wrdata);
    checkOutput({tag, "_busy"},   32'(o_busy),        32'(busy));
  endtask

  initial begin
    int order [5] = '{0, 1, 2, 3, 0};

    rst = 1'b1;
    i_data = '0;
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    #12;
    checkAll("reset", 4'b0000, 1'b0, 32'd0, 1'b0);
    checkOutput("reset_gnt", 32'(o_gnt_id), 32'd0);
    rst = 1'b0;
    tick();

    // All four producers send single-beat packets: 0,1,2,3,0.
    for (int k = 0; k < N_REQ; k++) setData(k, 8'(8'h10 + k));
    applyStimulus(4'b1111, 4'b1111, 1'b0);
    checkAll("rr_idle0", 4'b0000, 1'b0, 32'd0, 1'b0);
    tick();
    for (int n = 0; n < 5; n++) begin
      checkAll($sformatf("rr_lock%0d", n), 4'(1 << order[n]), 1'b1,
               expWr(order[n], 8'(8'h10 + order[n])), 1'b1);
      checkOutput($sformatf("rr_gnt%0d", n), 32'(o_gnt_id), 32'(order[n]));
      tick();
      checkAll($sformatf("rr_bubble%0d", n), 4'b0000, 1'b0, 32'd0, 1'b0);
      if (n == 4) begin
        setData(2, 8'hA0);
        setData(1, 8'hB0);
        applyStimulus(4'b0100, 4'b0000, 1'b0);
      end
      tick();
    end

    // Producer 2 three-beat packet while producer 1 also requests.
    applyStimulus(4'b0110, 4'b0000, 1'b0);
    checkOutput("mb_gnt", 32'(o_gnt_id), 32'd2);
    checkAll("mb_beat0", 4'b0100, 1'b1, expWr(2, 8'hA0), 1'b1);
    tick();
    setData(2, 8'hA1);
    checkAll("mb_beat1", 4'b0100, 1'b1, expWr(2, 8'hA1), 1'b1);
    tick();
    setData(2, 8'hA2);
    applyStimulus(4'b0110, 4'b0100, 1'b0);
    checkAll("mb_beat2", 4'b0100, 1'b1, expWr(2, 8'hA2), 1'b1);
    tick();
    applyStimulus(4'b0010, 4'b0000, 1'b0);
    checkAll("mb_bubble", 4'b0000, 1'b0, 32'd0, 1'b0);
    tick();

    // Producer 1 granted; FIFO full for 3 cycles after its first beat.
    checkOutput("full_gnt", 32'(o_gnt_id), 32'd1);
    checkAll("full_beat0", 4'b0010, 1'b1, expWr(1, 8'hB0), 1'b1);
    tick();
    setData(1, 8'hB1);
    applyStimulus(4'b0010, 4'b0000, 1'b1);
    for (int n = 0; n < 3; n++) begin
      checkAll($sformatf("full_hold%0d", n), 4'b0000, 1'b0, 32'd0, 1'b1);
      checkOutput($sformatf("full_gnt%0d", n), 32'(o_gnt_id), 32'd1);
      tick();
    end
    applyStimulus(4'b0010, 4'b0000, 1'b0);
    checkAll("full_beat1", 4'b0010, 1'b1, expWr(1, 8'hB1), 1'b1);
    tick();
    setData(1, 8'hB2);
    applyStimulus(4'b0010, 4'b0010, 1'b0);
    checkAll("full_beat2", 4'b0010, 1'b1, expWr(1, 8'hB2), 1'b1);
    tick();

    // Producer 3 packet with a 2-cycle valid gap while others request.
    setData(3, 8'hC0);
    applyStimulus(4'b1000, 4'b0000, 1'b0);
    checkAll("gap_idle", 4'b0000, 1'b0, 32'd0, 1'b0);
    tick();
    checkOutput("gap_gnt", 32'(o_gnt_id), 32'd3);
    checkAll("gap_beat0", 4'b1000, 1'b1, expWr(3, 8'hC0), 1'b1);
    tick();
    applyStimulus(4'b0111, 4'b0000, 1'b0);
    for (int n = 0; n < 2; n++) begin
      checkAll($sformatf("gap_hold%0d", n), 4'b1000, 1'b0, 32'd0, 1'b1);
      checkOutput($sformatf("gap_gnt%0d", n), 32'(o_gnt_id), 32'd3);
      tick();
    end
    setData(3, 8'hC1);
    applyStimulus(4'b1111, 4'b1000, 1'b0);
    checkAll("gap_beat1", 4'b1000, 1'b1, expWr(3, 8'hC1), 1'b1);
    tick();

    // Async reset in the middle of a producer 2 packet.
    setData(2, 8'hD0);
    applyStimulus(4'b0100, 4'b0000, 1'b0);
    tick();
    checkOutput("rst_pre_gnt", 32'(o_gnt_id), 32'd2);
    checkAll("rst_pre", 4'b0100, 1'b1, expWr(2, 8'hD0), 1'b1);
    rst = 1'b1;
    checkAll("rst_mid", 4'b0000, 1'b0, 32'd0, 1'b0);
    checkOutput("rst_mid_gnt", 32'(o_gnt_id), 32'd0);
    rst = 1'b0;
    setData(0, 8'h0E);
    applyStimulus(4'b1111, 4'b1111, 1'b0);
    tick();
    checkOutput("rst_post_gnt", 32'(o_gnt_id), 32'd0);
    checkAll("rst_post", 4'b0001, 1'b1, expWr(0, 8'h0E), 1'b1);
    tick();

    // Producer 3 writes 0x5C (source-id tagged word when enabled).
    setData(3, 8'h5C);
    applyStimulus(4'b1000, 4'b1000, 1'b0);
    tick();
    checkOutput("sid_gnt", 32'(o_gnt_id), 32'd3);
    checkAll("sid_beat", 4'b1000, 1'b1, expWr(3, 8'h5C), 1'b1);
    tick();
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    checkAll("sid_done", 4'b0000, 1'b0, 32'd0, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
